// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// Each grant captures the winner's byte, strobes the transmitter once, and acks on its done tick.
module uart_tx_arbiter #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned N_REQ     = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ*DATA_BITS-1:0]   i_data,
    output logic [N_REQ-1:0]             o_grant,
    output logic [N_REQ-1:0]             o_ack,
    output logic                         o_tx_start,
    output logic [DATA_BITS-1:0]         o_tx_data,
    input  logic                         i_tx_done_tick,
    output logic                         o_busy
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StAck} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [PtrW-1:0]        win_idx, cand;
    logic                   win_valid;

    // First set request at ptr, ptr+1, ... wrapping modulo N_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PtrW'((32'(ptr_q) + i) % N_REQ);
            if (!win_valid && i_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d = N_REQ'(1) << win_idx;
                    data_d  = i_data[32'(win_idx)*DATA_BITS +: DATA_BITS];
                    ptr_d   = PtrW'((32'(win_idx) + 1) % N_REQ);
                    state_d = StStart;
                end
            end
            StStart:    state_d = StWaitDone;
            StWaitDone: if (i_tx_done_tick) state_d = StAck;
            StAck: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_tx_data  = data_q;
    assign o_tx_start = (state_q == StStart);
    assign o_ack      = (state_q == StAck) ? grant_q : '0;
    assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: models requesters and a UART that returns a done tick after a delay.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  grant, ack;
    logic        tx_start, busy;
    logic [7:0]  tx_data;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } xfer_t;

    xfer_t      exp_q[$], obs_q[$];
    logic [3:0] exp_ack_q[$], ack_q[$];
    int         idle_q[$];
    int         tests = 0, fails = 0;
    int         uart_cnt = 0, done_delay = 3, idle_run = 0;
    logic [3:0] keep = 4'b0;

    uart_tx_arbiter #(.DATA_BITS(8), .N_REQ(4)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req          (req),
        .i_data         (data),
        .o_grant        (grant),
        .o_ack          (ack),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .i_tx_done_tick (done),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // One cycle: record DUT events, play the UART and the requesters for the next edge.
    task automatic step();
        xfer_t ev;
        @(posedge clk);
        #1;
        done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) done = 1'b1;
        end
        if (tx_start) begin
            ev.grant = grant;
            ev.data  = tx_data;
            obs_q.push_back(ev);
            idle_q.push_back(idle_run);
            idle_run = 0;
            uart_cnt = done_delay;
        end
        if (ack != 4'b0) begin
            ack_q.push_back(ack);
            for (int k = 0; k < 4; k++) if (ack[k] && !keep[k]) req[k] = 1'b0;
        end
        if (!busy) idle_run++;
    endtask

    task automatic run_until(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (req == 4'b0 && !busy && uart_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 4'b0; done = 1'b0; uart_cnt = 0; keep = 4'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); exp_ack_q.delete(); ack_q.delete(); idle_q.delete();
    endtask

    task automatic expect_xfer(input logic [3:0] g, input logic [7:0] d);
        xfer_t e;
        e.grant = g;
        e.data  = d;
        exp_q.push_back(e);
        exp_ack_q.push_back(g);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0; data = 32'hDEAD_BEEF; done = 1'b0;
        step();
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL rst_grant: got %b want 0000", grant); end
        tests++; if (ack !== 4'b0) begin fails++; $display("FAIL rst_ack: got %b want 0000", ack); end
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", tx_start); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", tx_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        xfer_t e, o;
        logic [3:0] a, ea;
        clear_q();
        done_delay = 20;
        data = 32'h0000_A500;
        req  = 4'b0010;
        expect_xfer(4'b0010, 8'hA5);
        step();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", grant); end
        tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            fails++; $display("FAIL single_start: got start %b data %h want 1 A5", tx_start, tx_data);
        end
        step();
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_start_len: got %b want 0", tx_start); end
        run_until(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_timeout: got busy %b want idle", busy); end
        tests++;
        if (obs_q.size() != exp_q.size() || ack_q.size() != exp_ack_q.size()) begin
            fails++; $display("FAIL single_count: got %0d starts %0d ack cycles want %0d %0d",
                              obs_q.size(), ack_q.size(), exp_q.size(), exp_ack_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL single_xfer: got %h want %h", o, e); end
        end
        while (exp_ack_q.size() > 0 && ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); a = ack_q.pop_front();
            tests++; if (a !== ea) begin fails++; $display("FAIL single_ack: got %b want %b", a, ea); end
        end
        tests++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL single_release: got grant %b busy %b want 0000 0", grant, busy);
        end
    endtask

    task automatic test_all_req();
        bit ok;
        xfer_t e, o;
        logic [3:0] a, ea;
        apply_reset();
        clear_q();
        done_delay = 2;
        data = 32'h4433_2211;
        for (int k = 0; k < 4; k++) expect_xfer(4'(1 << k), data[k*8 +: 8]);
        req = 4'b1111;
        run_until(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL all_timeout: got busy %b req %b want idle", busy, req); end
        tests++;
        if (obs_q.size() != 4 || ack_q.size() != 4) begin
            fails++; $display("FAIL all_count: got %0d starts %0d acks want 4 4", obs_q.size(), ack_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL all_xfer: got %h want %h", o, e); end
        end
        while (exp_ack_q.size() > 0 && ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); a = ack_q.pop_front();
            tests++; if (a !== ea) begin fails++; $display("FAIL all_ack: got %b want %b", a, ea); end
        end
        for (int i = 1; i < idle_q.size(); i++) begin
            tests++;
            if (idle_q[i] != 1) begin fails++; $display("FAIL all_idle_gap: got %0d want 1", idle_q[i]); end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        xfer_t e, o;
        apply_reset();
        clear_q();
        done_delay = 2;
        data = 32'h00CC_00AA;
        // Both hold their request; once four grants are seen they drop on their next ack.
        expect_xfer(4'b0001, 8'hAA); expect_xfer(4'b0100, 8'hCC);
        expect_xfer(4'b0001, 8'hAA); expect_xfer(4'b0100, 8'hCC);
        expect_xfer(4'b0001, 8'hAA);
        keep = 4'b0101;
        req  = 4'b0101;
        for (int i = 0; i < 200 && obs_q.size() < 4; i++) step();
        keep = 4'b0;
        run_until(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL fair_timeout: got busy %b req %b want idle", busy, req); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL fair_count: got %0d grants want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL fair_order: got %h want %h", o, e); end
        end
    endtask

    task automatic test_data_change();
        xfer_t e, o;
        clear_q();
        done_delay = 5;
        data = 32'h0000_3C00;
        req  = 4'b0010;
        expect_xfer(4'b0010, 8'h3C);
        step();
        data = 32'h0000_FF00;
        for (int i = 0; i < 50 && busy; i++) begin
            tests++;
            if (tx_data !== 8'h3C) begin fails++; $display("FAIL hold_data: got %h want 3C", tx_data); end
            step();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_timeout: got busy %b want 0", busy); end
        tests++;
        if (obs_q.size() != 1 || ack_q.size() != 1) begin
            fails++; $display("FAIL hold_count: got %0d starts %0d acks want 1 1", obs_q.size(), ack_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL hold_xfer: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        xfer_t e, o;
        clear_q();
        done_delay = 1000;
        data = 32'h005A_0000;
        req  = 4'b0100;
        step();
        for (int i = 0; i < 30; i++) step();
        tests++;
        if (busy !== 1'b1 || grant !== 4'b0100 || ack !== 4'b0) begin
            fails++; $display("FAIL no_timeout: got busy %b grant %b ack %b want 1 0100 0000", busy, grant, ack);
        end
        rst = 1'b1; req = 4'b0; uart_cnt = 0;
        step();
        tests++;
        if ({grant, ack, tx_start, tx_data, busy} !== 18'b0) begin
            fails++; $display("FAIL mid_rst_out: got grant %b ack %b start %b data %h busy %b want all 0",
                              grant, ack, tx_start, tx_data, busy);
        end
        tests++; if (ack_q.size() != 0) begin fails++; $display("FAIL mid_rst_ack: got %0d acks want 0", ack_q.size()); end
        clear_q();
        rst = 1'b0;
        done_delay = 2;
        data = 32'h7700_0066;
        req  = 4'b1001;
        expect_xfer(4'b0001, 8'h66);
        expect_xfer(4'b1000, 8'h77);
        step();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL mid_rst_ptr: got %b want 0001", grant); end
        run_until(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL mid_rst_timeout: got busy %b want idle", busy); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL mid_rst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL mid_rst_xfer: got %h want %h", o, e); end
        end
    endtask

    task automatic test_spurious();
        bit ok;
        xfer_t e, o;
        clear_q();
        req  = 4'b0;
        done = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0 || ack !== 4'b0 || grant !== 4'b0) begin
            fails++; $display("FAIL spur_idle: got busy %b ack %b grant %b want 0 0000 0000", busy, ack, grant);
        end
        done_delay = 4;
        data = 32'h0000_E700;
        req  = 4'b0010;
        expect_xfer(4'b0010, 8'hE7);
        step();
        done = 1'b1;
        step();
        tests++;
        if (ack !== 4'b0 || busy !== 1'b1 || tx_start !== 1'b0) begin
            fails++; $display("FAIL spur_start: got ack %b busy %b start %b want 0000 1 0", ack, busy, tx_start);
        end
        step();
        tests++; if (ack !== 4'b0) begin fails++; $display("FAIL spur_start_ack: got %b want 0000", ack); end
        run_until(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL spur_timeout: got busy %b want idle", busy); end
        tests++;
        if (obs_q.size() != 1 || ack_q.size() != 1) begin
            fails++; $display("FAIL spur_count: got %0d starts %0d acks want 1 1", obs_q.size(), ack_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL spur_xfer: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_fairness();
        test_data_change();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8, width of one transmitted character.
REQ-002 Parameter N_REQ, default 4, number of requesters, legal range 2..8.
REQ-003 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_req  input  N_REQ  per-requester level request; held high until that requester's o_ack.
REQ-006 i_data  input  N_REQ*DATA_BITS  packed bytes; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
REQ-007 o_grant  output  N_REQ  one-hot owner of the UART transmitter; all-zero when idle.
REQ-008 o_ack  output  N_REQ  one-hot, single-cycle pulse; the granted byte has fully left the line.
REQ-009 o_tx_start  output  1  single-cycle start strobe to the UART transmitter.
REQ-010 o_tx_data  output  DATA_BITS  byte presented to the UART transmitter; held stable from grant until release.
REQ-011 i_tx_done_tick  input  1  single-cycle done pulse from the UART transmitter, at end of stop bit.
REQ-012 o_busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, START, WAIT_DONE, ACK. All outputs SHALL be registered or decoded from state only.
REQ-014 IDLE with any i_req bit high SHALL do three things at the next edge: pick winner k, register o_grant = 1<<k and o_tx_data = i_data slice k, and enter START.
REQ-015 Winner selection SHALL be round-robin.
- Search order: first set i_req bit at index ptr, ptr+1, ..., wrapping modulo N_REQ.
- ptr is a clog2(N_REQ)-bit register.
REQ-016 ptr SHALL update to (k+1) mod N_REQ at the edge that grants k. It SHALL NOT change otherwise.
REQ-017 START SHALL last exactly one cycle with o_tx_start = 1, then enter WAIT_DONE unconditionally.
REQ-018 o_tx_start SHALL be 1 only in START. It SHALL never be high for two consecutive cycles.
REQ-019 WAIT_DONE SHALL hold o_grant and o_tx_data unchanged and stay until i_tx_done_tick = 1 is sampled, then enter ACK.
REQ-020 ACK SHALL last exactly one cycle with o_ack = o_grant, then enter IDLE with o_grant cleared to zero.
REQ-021 i_tx_done_tick SHALL be ignored in IDLE, START and ACK.
REQ-022 Latency: i_req sampled high in IDLE at edge E.
- o_grant is valid from E.
- o_tx_start is high for cycle E..E+1.
- o_ack is high for the cycle after the edge that samples i_tx_done_tick.
REQ-023 The selected requester's i_data SHALL be captured only at the grant edge. Later changes to it SHALL NOT affect the byte sent.
REQ-024 If the granted requester deasserts i_req before the done tick, the transfer SHALL still complete and o_ack SHALL still pulse.
REQ-025 Changes to non-granted i_req bits during START, WAIT_DONE or ACK SHALL have no effect until the next IDLE.
REQ-026 Requesters drop i_req on sampling o_ack, so the earliest re-request from the same requester is seen in IDLE the cycle after ACK.
REQ-027 If that requester is still high while others also request, rotation of ptr SHALL give the others priority.
REQ-028 Back-to-back throughput: IDLE lasts one cycle between successive grants when requests are pending.
REQ-029 There SHALL be no timeout. WAIT_DONE persists indefinitely without i_tx_done_tick.

Reset
REQ-030 When i_reset is high at an edge, the block SHALL set:
- state = IDLE, ptr = 0
- o_grant = 0, o_ack = 0, o_tx_start = 0, o_tx_data = 0, o_busy = 0
REQ-031 Reset in START or WAIT_DONE SHALL abandon the in-flight byte with no o_ack. The UART transmitter is reset by the same i_reset.
REQ-032 On the first edge after i_reset falls, the block SHALL behave as IDLE with ptr = 0.

Verification
REQ-033 Single request.
- Stimulus: after reset, i_req = 0010, slice 1 = 8'hA5, done tick 20 cycles after start.
- Response: o_grant = 0010 one edge later; o_tx_start for one cycle with o_tx_data = A5; o_ack = 0010 for one cycle after the done tick; then o_grant = 0 and o_busy = 0.
REQ-034 All requesting, with the bench modelling requesters that drop i_req on o_ack.
- Stimulus: i_req = 1111 held, ptr = 0.
- Response: grants in order 0,1,2,3, each separated by exactly one IDLE cycle.
REQ-035 Fairness.
- Stimulus: requester 0 re-requests immediately after every ack, while requester 2 stays high.
- Response: grants alternate 0,2,0,2.
REQ-036 Data change after grant.
- Stimulus: i_data slice 1 changes from 8'h3C to 8'hFF after the grant.
- Response: o_tx_data remains 3C until ACK completes.
REQ-037 Reset mid-transfer.
- Stimulus: i_reset asserted in WAIT_DONE.
- Response: all outputs are 0 on the next cycle, no o_ack is issued, and the next request from index 0 wins.
REQ-038 Spurious done tick.
- Stimulus: i_tx_done_tick pulsed while in IDLE and while in START.
- Response: no state change and no o_ack.
